ds_wavegen_multi: RTL and testbench

- Multi-channel waveform source that feeds the delta-sigma PWM modulator input. It generalises the single-channel triangle generator to NUM_CH channels.
- Each channel holds a phase accumulator and a per-channel mode: off, triangle, saw or square.
- One shared adder is time-multiplexed across the channels. On each tick (normally pulse_done) the channels are stepped in order and their outputs are summed into one mix sample.
- Registers are written through the existing byte-pair host protocol.

---
 rtl/ds_wavegen_multi.sv | 201 ++++++++++++++++++++
 tb/tb_ds_wavegen_multi.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds_wavegen_multi.sv
// Multi-channel waveform source for the delta-sigma modulator input.
// One shared adder walks the channels in order on each tick and emits their summed output.
module ds_wavegen_multi #(
  parameter int NUM_CH     = 4,
  parameter int ACC_BITS   = 16,
  parameter int DELTA_BITS = 14,
  parameter int ADDR_BITS  = 4,
  localparam int MIX_BITS  = ACC_BITS + $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           data_in,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 data_part_in,
  input  logic                 tick,
  output logic [MIX_BITS-1:0]  mix_out,
  output logic                 mix_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, STEP, EMIT} state_t;

  state_t state, state_n;
  logic   pending, pending_n, ovr_n, start;

  logic [2:0]  sync;
  logic        dp, dp_last;
  logic [7:0]  data_low;
  logic [15:0] word;
  logic        in_range, wr_phase, wr_ctrl;
  logic [ADDR_BITS-1:0] host_ch;

  logic [ACC_BITS-1:0]   phase [NUM_CH];
  logic [DELTA_BITS-1:0] delta [NUM_CH];
  logic [1:0]            mode  [NUM_CH];
  logic                  down  [NUM_CH];

  logic [CH_W-1:0]     ch;
  logic [MIX_BITS-1:0] acc_sum;
  logic [ACC_BITS-1:0] cur_phase, delta_ext, up_val, dn_val, chan_out, seq_phase;
  logic [1:0]          cur_mode;
  logic                cur_down, seq_down;

  // sync[1] is the synchronised strobe, sync[2] its previous value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 3'b111;
    else        sync <= {sync[1:0], data_part_in};
  end

  assign dp      = sync[1];
  assign dp_last = sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              data_low <= '0;
    else if (!dp && dp_last) data_low <= data_in;
  end

  assign word     = {data_in, data_low};
  assign in_range = ({1'b0, addr} < (ADDR_BITS+1)'(2 * NUM_CH));
  assign host_ch  = addr >> 1;
  assign wr_phase = dp && !dp_last && in_range && !addr[0];
  assign wr_ctrl  = dp && !dp_last && in_range && addr[0];

  // Datapath for the channel currently selected by the sequencer
  always_comb begin
    cur_phase = phase[ch];
    cur_mode  = mode[ch];
    cur_down  = down[ch];
    delta_ext = ACC_BITS'(delta[ch]);
    up_val    = cur_phase + delta_ext;
    dn_val    = cur_phase - delta_ext;
    chan_out  = '0;
    seq_phase = cur_phase;
    seq_down  = cur_down;
    case (cur_mode)
      2'b01: begin
        chan_out = cur_phase;
        if (!cur_down) begin
          if (up_val[ACC_BITS-1 -: 2] == 2'b11) seq_down  = 1'b1;
          else                                  seq_phase = up_val;
        end else begin
          if (dn_val[ACC_BITS-1 -: 2] == 2'b00) seq_down  = 1'b0;
          else                                  seq_phase = dn_val;
        end
      end
      2'b10: begin
        chan_out  = cur_phase;
        seq_phase = up_val;
      end
      2'b11: begin
        chan_out  = {ACC_BITS{cur_phase[ACC_BITS-1]}};
        seq_phase = up_val;
      end
      default: ;
    endcase
  end

  // Host writes are applied after the sequencer update so they take priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        phase[c] <= '0;
        delta[c] <= '0;
        mode[c]  <= 2'b00;
        down[c]  <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (state == STEP && ch == CH_W'(c)) begin
          phase[c] <= seq_phase;
          down[c]  <= seq_down;
        end
        if (wr_phase && host_ch == ADDR_BITS'(c)) begin
          phase[c] <= ACC_BITS'(word);
          down[c]  <= 1'b0;
        end
        if (wr_ctrl && host_ch == ADDR_BITS'(c)) begin
          delta[c] <= word[DELTA_BITS-1:0];
          mode[c]  <= word[15:14];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      overrun <= ovr_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    ovr_n     = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (tick || pending) begin
          state_n   = STEP;
          start     = 1'b1;
          pending_n = tick && pending;
        end
      end
      STEP: begin
        if (tick) begin
          if (pending) ovr_n     = 1'b1;
          else         pending_n = 1'b1;
        end
        if (ch == LAST_CH) state_n = EMIT;
      end
      EMIT: begin
        if (pending) begin
          state_n   = STEP;
          start     = 1'b1;
          pending_n = 1'b0;
          ovr_n     = tick;
        end else begin
          state_n   = IDLE;
          pending_n = tick;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // mix_out and mix_valid are registered together on the last channel's step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch        <= '0;
      acc_sum   <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (start) begin
        ch      <= '0;
        acc_sum <= '0;
      end else if (state == STEP) begin
        ch      <= ch + 1'b1;
        acc_sum <= acc_sum + MIX_BITS'(chan_out);
        if (ch == LAST_CH) begin
          mix_out   <= acc_sum + MIX_BITS'(chan_out);
          mix_valid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ds_wavegen_multi.sv
// Self-checking bench for ds_wavegen_multi against a per-tick arithmetic model of the channels.
module tb_ds_wavegen_multi;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = '0;
  logic [3:0]  addr = '0;
  logic        data_part_in = 1'b1;
  logic        tick = 1'b0;
  logic [17:0] mix_out;
  logic        mix_valid, busy, overrun;

  int checks = 0;
  int passes = 0;

  int m_phase [NCH];
  int m_delta [NCH];
  int m_mode  [NCH];
  int m_down  [NCH];

  ds_wavegen_multi dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .addr(addr),
    .data_part_in(data_part_in), .tick(tick), .mix_out(mix_out),
    .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_phase[c] = 0; m_delta[c] = 0; m_mode[c] = 0; m_down[c] = 0;
    end
  endtask

  // Sum of outputs taken from pre-update phases, then every channel advances
  function automatic int model_tick();
    int sum = 0;
    int n;
    for (int c = 0; c < NCH; c++) begin
      case (m_mode[c])
        1: sum += m_phase[c];
        2: sum += m_phase[c];
        3: sum += (m_phase[c] >= 32768) ? 65535 : 0;
        default: ;
      endcase
      if (m_mode[c] == 2 || m_mode[c] == 3) begin
        m_phase[c] = (m_phase[c] + m_delta[c]) % 65536;
      end else if (m_mode[c] == 1) begin
        if (m_down[c] == 0) begin
          n = (m_phase[c] + m_delta[c]) % 65536;
          if (n >= 49152) m_down[c] = 1;
          else            m_phase[c] = n;
        end else begin
          n = (m_phase[c] - m_delta[c] + 65536) % 65536;
          if (n < 16384) m_down[c] = 0;
          else           m_phase[c] = n;
        end
      end
    end
    return sum;
  endfunction

  task automatic host_write(input int a, input int v);
    logic [15:0] vv;
    vv = v[15:0];
    addr = a[3:0];
    data_in = vv[7:0];
    data_part_in = 1'b0;
    repeat (4) cyc();
    data_in = vv[15:8];
    data_part_in = 1'b1;
    repeat (4) cyc();
    if (a < 2 * NCH) begin
      if (a % 2 == 0) begin
        m_phase[a/2] = v & 16'hFFFF;
        m_down[a/2] = 0;
      end else begin
        m_delta[a/2] = v & 16'h3FFF;
        m_mode[a/2] = (v >> 14) & 3;
      end
    end
  endtask

  task automatic do_tick_expect(input string name);
    int exp_v, lat;
    exp_v = model_tick();
    tick = 1'b1;
    lat = 0;
    do begin
      cyc();
      lat++;
      tick = 1'b0;
    end while (!mix_valid && lat < 20);
    checks++;
    if (lat !== NCH + 1) $display("FAIL %s latency: got %0d want %0d", name, lat, NCH + 1);
    else passes++;
    checks++;
    if (mix_out !== 18'(exp_v)) $display("FAIL %s mix_out: got %h want %h", name, mix_out, 18'(exp_v));
    else passes++;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_part_in = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({mix_out, mix_valid, busy, overrun} !== 21'd0)
      $display("FAIL reset_outputs: got %h/%b/%b/%b want 0/0/0/0", mix_out, mix_valid, busy, overrun);
    else passes++;
    rst_n = 1'b1;
    model_reset();
    cyc();
  endtask

  task automatic test_all_off();
    int valid_at = -1;
    int busy_bad = 0;
    tick = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      tick = 1'b0;
      if (mix_valid) begin
        if (valid_at == -1) valid_at = k;
        else valid_at = 99;
      end
      if (busy !== ((k >= 1 && k <= 5) ? 1'b1 : 1'b0)) busy_bad++;
      if (k == 5) begin
        checks++;
        if (mix_out !== 18'd0) $display("FAIL off_mix: got %h want 0", mix_out);
        else passes++;
      end
    end
    checks++;
    if (valid_at !== 5) $display("FAIL off_valid_cycle: got %0d want 5", valid_at);
    else passes++;
    checks++;
    if (busy_bad !== 0) $display("FAIL off_busy_window: got %0d bad cycles want 0", busy_bad);
    else passes++;
    void'(model_tick());
  endtask

  task automatic test_saw();
    host_write(1, 16'h9000);
    host_write(0, 16'hF800);
    do_tick_expect("saw_first");
    do_tick_expect("saw_wrap");
    host_write(1, 0);
  endtask

  task automatic test_triangle();
    host_write(1, 16'h5000);
    host_write(0, 16'hB800);
    do_tick_expect("tri_t1");
    do_tick_expect("tri_t2");
    do_tick_expect("tri_t3");
    do_tick_expect("tri_t4");
    host_write(1, 0);
  endtask

  task automatic test_square_mix();
    host_write(3, 16'hC000);
    host_write(2, 16'h8000);
    host_write(5, 16'h8000);
    host_write(4, 16'h1234);
    checks++;
    if (model_tick() !== 32'h11233) $display("FAIL square_model: got %h want 11233", 32'h11233);
    else passes++;
    host_write(2, 16'h8000);
    host_write(4, 16'h1234);
    do_tick_expect("square_saw_mix");
    host_write(3, 0);
    host_write(5, 0);
  endtask

  task automatic test_back_to_back();
    int v_first = -1, v_second = -1, ovr_at = -1, ovr_cnt = 0, e1, e2;
    host_write(3, 16'h8100);
    host_write(2, 16'h0400);
    e1 = model_tick();
    e2 = model_tick();
    for (int k = 0; k < 16; k++) begin
      tick = (k < 3) ? 1'b1 : 1'b0;
      cyc();
      if (overrun) begin ovr_cnt++; ovr_at = k + 1; end
      if (mix_valid) begin
        if (v_first == -1) begin
          v_first = k + 1;
          checks++;
          if (mix_out !== 18'(e1)) $display("FAIL b2b_mix1: got %h want %h", mix_out, 18'(e1));
          else passes++;
        end else begin
          v_second = k + 1;
          checks++;
          if (mix_out !== 18'(e2)) $display("FAIL b2b_mix2: got %h want %h", mix_out, 18'(e2));
          else passes++;
        end
      end
    end
    tick = 1'b0;
    checks++;
    if (v_first !== 5 || v_second !== 10)
      $display("FAIL b2b_valid_cycles: got %0d,%0d want 5,10", v_first, v_second);
    else passes++;
    checks++;
    if (ovr_cnt !== 1 || ovr_at !== 3)
      $display("FAIL b2b_overrun: got count %0d at %0d want 1 at 3", ovr_cnt, ovr_at);
    else passes++;
    host_write(3, 0);
  endtask

  task automatic test_collision();
    int exp_v, lat;
    host_write(1, 16'h5000);
    host_write(0, 16'hB800);
    do_tick_expect("coll_setup");
    addr = 4'd0;
    data_in = 8'h00;
    data_part_in = 1'b0;
    repeat (4) cyc();
    data_in = 8'h40;
    data_part_in = 1'b1;
    cyc();
    tick = 1'b1;
    exp_v = model_tick();
    m_phase[0] = 16'h4000;
    m_down[0] = 0;
    lat = 0;
    do begin
      cyc();
      lat++;
      tick = 1'b0;
    end while (!mix_valid && lat < 20);
    checks++;
    if (!mix_valid || mix_out !== 18'(exp_v))
      $display("FAIL coll_mix: got %h valid %b want %h", mix_out, mix_valid, 18'(exp_v));
    else passes++;
    cyc();
    do_tick_expect("coll_host_phase");
    do_tick_expect("coll_dir_up");
    for (int i = 0; i < 6; i++) host_write(8 + $urandom_range(0, 7), $urandom_range(0, 65535));
    do_tick_expect("ignored_addr");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NCH; c++) begin
        host_write(2 * c + 1, ($urandom_range(0, 3) << 14) | $urandom_range(0, 16'h3FFF));
        host_write(2 * c, $urandom_range(0, 65535));
      end
      for (int t = 0; t < 4; t++) do_tick_expect($sformatf("rand_r%0d_t%0d", r, t));
    end
  endtask

  task automatic test_reset_mid();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mix_out, mix_valid, busy, overrun} !== 21'd0)
      $display("FAIL mid_reset: got %h/%b/%b/%b want 0/0/0/0", mix_out, mix_valid, busy, overrun);
    else passes++;
    cyc();
    rst_n = 1'b1;
    model_reset();
    cyc();
    do_tick_expect("after_mid_reset");
  endtask

  initial begin
    test_reset();
    test_all_off();
    test_saw();
    test_triangle();
    test_square_mix();
    test_back_to_back();
    test_collision();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
